// File: rtl/timerio.sv
// 16-bit programmable interval timer for the 6801 bus. It has an 8-bit prescaler,
// auto-reload or one-shot modes, and a coherent two-byte count read.
module timerio #(
  parameter logic [7:0] RESET_PRESCALE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq
);

  localparam logic [2:0] A_CTRL = 3'd0, A_STAT = 3'd1, A_RLH = 3'd2, A_RLL = 3'd3;
  localparam logic [2:0] A_CNTH = 3'd4, A_CNTL = 3'd5, A_PS  = 3'd6;

  logic [2:0]  ctrl_q, ctrl_d;
  logic        tof_q, tof_d;
  logic [15:0] reload_q, reload_d;
  logic [7:0]  rh_stg_q, rh_stg_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  cl_snap_q, cl_snap_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [7:0]  prescale_q, prescale_d;

  logic wr, rd, wr_ctrl, wr_rll, en, auto_rl, tick, tick_eff, expire;

  assign wr      = cs & ~rw;
  assign rd      = cs & rw;
  assign wr_ctrl = wr && (AD == A_CTRL);
  assign wr_rll  = wr && (AD == A_RLL);
  assign en      = ctrl_q[0];
  assign auto_rl = ctrl_q[1];
  assign tick    = en && (pcnt_q == prescale_q);
  // A RELOAD_L write or a CTRL write that stops the timer overrides a tick on the same edge.
  assign tick_eff = tick && !wr_rll && !(wr_ctrl && !DI[0]);
  assign expire   = tick_eff && (count_q == 16'd0);

  always_comb begin
    ctrl_d     = ctrl_q;
    tof_d      = tof_q;
    reload_d   = reload_q;
    rh_stg_d   = rh_stg_q;
    count_d    = count_q;
    cl_snap_d  = cl_snap_q;
    pcnt_d     = pcnt_q;
    prescale_d = prescale_q;

    if (wr_rll || (wr_ctrl && DI[0] && !en)) pcnt_d = 8'd0;
    else if (en) pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;

    if (wr_rll) count_d = {rh_stg_q, DI};
    else if (tick_eff) begin
      if (count_q != 16'd0) count_d = count_q - 16'd1;
      else if (auto_rl)     count_d = reload_q;
    end

    if (wr && (AD == A_STAT) && DI[0]) tof_d = 1'b0;
    if (expire) tof_d = 1'b1;

    if (wr_ctrl) ctrl_d = DI[2:0];
    else if (expire && !auto_rl) ctrl_d[0] = 1'b0;

    if (wr && (AD == A_RLH)) rh_stg_d = DI;
    if (wr_rll) reload_d = {rh_stg_q, DI};
    if (wr && (AD == A_PS)) prescale_d = DI;
    // The snapshot takes the count from before this edge, so it matches the high byte returned.
    if (rd && (AD == A_CNTH)) cl_snap_d = count_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q     <= 3'd0;
      tof_q      <= 1'b0;
      reload_q   <= 16'd0;
      rh_stg_q   <= 8'd0;
      count_q    <= 16'd0;
      cl_snap_q  <= 8'd0;
      pcnt_q     <= 8'd0;
      prescale_q <= RESET_PRESCALE;
    end else begin
      ctrl_q     <= ctrl_d;
      tof_q      <= tof_d;
      reload_q   <= reload_d;
      rh_stg_q   <= rh_stg_d;
      count_q    <= count_d;
      cl_snap_q  <= cl_snap_d;
      pcnt_q     <= pcnt_d;
      prescale_q <= prescale_d;
    end
  end

  always_comb begin
    DO = 8'h00;
    case (AD)
      A_CTRL:  DO = {5'd0, ctrl_q};
      A_STAT:  DO = {6'd0, en, tof_q};
      A_RLH:   DO = reload_q[15:8];
      A_RLL:   DO = reload_q[7:0];
      A_CNTH:  DO = count_q[15:8];
      A_CNTL:  DO = cl_snap_q;
      A_PS:    DO = prescale_q;
      default: DO = 8'h00;
    endcase
  end

  assign irq = tof_q & ctrl_q[2];

endmodule

// File: tb/tb_timerio.sv
// Directed bench for timerio. Bus cycles start on a falling edge and span one rising edge.
// Expected values are worked out by hand from the timer's register behaviour.
module tb_timerio;
  localparam logic [7:0] RST_PS = 8'h5A;

  logic       clk, rst, rw, cs, irq;
  logic [2:0] AD;
  logic [7:0] DI, DO;
  int checks = 0;
  int failures = 0;

  timerio #(.RESET_PRESCALE(RST_PS)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    AD = a; DI = d; rw = 1'b0; cs = 1'b1;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic bus_wr_nocs(input logic [2:0] a, input logic [7:0] d);
    AD = a; DI = d; rw = 1'b0; cs = 1'b0;
    @(negedge clk);
    rw = 1'b1;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] v;
    AD = a; rw = 1'b1; cs = 1'b1;
    #1 v = DO;
    @(negedge clk);
    cs = 1'b0;
    check(tag, v, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset state
    check("rst_irq", {7'd0, irq}, 8'h00);
    rd_chk(3'd0, 8'h00, "rst_ctrl");
    rd_chk(3'd1, 8'h00, "rst_stat");
    rd_chk(3'd2, 8'h00, "rst_rlh");
    rd_chk(3'd3, 8'h00, "rst_rll");
    rd_chk(3'd4, 8'h00, "rst_cnth");
    rd_chk(3'd5, 8'h00, "rst_cntl");
    rd_chk(3'd6, RST_PS, "rst_ps");
    rd_chk(3'd7, 8'h00, "rst_a7");

    // Auto-reload with (3+1)*(4+1) = 20 clock period
    bus_wr(3'd6, 8'h03);
    bus_wr(3'd2, 8'h00);
    bus_wr(3'd3, 8'h04);
    bus_wr(3'd0, 8'h07);               // enable edge E0
    idle(19);
    check("ar_irq_pre", {7'd0, irq}, 8'h00);
    rd_chk(3'd1, 8'h02, "ar_stat_e19");
    check("ar_irq_set", {7'd0, irq}, 8'h01);
    rd_chk(3'd1, 8'h03, "ar_stat_e20");
    bus_wr(3'd1, 8'h01);               // clear at E22
    check("ar_irq_clr", {7'd0, irq}, 8'h00);
    idle(17);
    rd_chk(3'd1, 8'h02, "ar_stat_e39");
    rd_chk(3'd1, 8'h03, "ar_stat_e40");
    check("ar_irq_set2", {7'd0, irq}, 8'h01);
    bus_wr(3'd0, 8'h00);
    bus_wr(3'd1, 8'h01);
    rd_chk(3'd1, 8'h00, "ar_stat_off");

    // TOF clear write lands on the edge that sets TOF: set wins
    bus_wr(3'd3, 8'h04);
    bus_wr(3'd0, 8'h07);               // E0
    idle(19);
    bus_wr(3'd1, 8'h01);               // covers E20
    rd_chk(3'd1, 8'h03, "col_tof_set_wins");
    bus_wr(3'd0, 8'h00);
    bus_wr(3'd1, 8'h01);

    // One-shot: TOF three clocks after enable, EN auto-clears
    bus_wr(3'd6, 8'h00);
    bus_wr(3'd3, 8'h02);
    bus_wr(3'd0, 8'h01);               // E0
    idle(2);
    rd_chk(3'd1, 8'h02, "os_stat_e2");
    rd_chk(3'd1, 8'h01, "os_stat_e3");
    rd_chk(3'd0, 8'h00, "os_ctrl");
    check("os_irq_ie0", {7'd0, irq}, 8'h00);
    rd_chk(3'd4, 8'h00, "os_cnth");
    rd_chk(3'd5, 8'h00, "os_cntl");
    bus_wr(3'd1, 8'h01);
    idle(5);
    rd_chk(3'd1, 8'h00, "os_no_retrig");

    // Coherent read, and RELOAD_L write on a tick edge
    bus_wr(3'd2, 8'h01);
    bus_wr(3'd3, 8'h00);
    bus_wr(3'd0, 8'h01);
    idle(3);
    bus_wr(3'd3, 8'h00);               // tick edge Ew: count must be exactly 0100
    rd_chk(3'd4, 8'h01, "coh_cnth");   // snapshot 00 taken at Ew+1
    idle(2);
    rd_chk(3'd5, 8'h00, "coh_cntl_snap");
    rd_chk(3'd4, 8'h00, "coh_cnth2");  // count 00FC after Ew+4
    rd_chk(3'd5, 8'hFC, "coh_cntl2");
    bus_wr(3'd0, 8'h00);
    rd_chk(3'd2, 8'h01, "coh_rlh");
    rd_chk(3'd3, 8'h00, "coh_rll");
    rd_chk(3'd1, 8'h00, "coh_stat");

    // Bus hygiene
    bus_wr(3'd7, 8'hFF);
    bus_wr_nocs(3'd6, 8'h55);
    bus_wr_nocs(3'd0, 8'h07);
    bus_wr_nocs(3'd3, 8'h33);
    rd_chk(3'd6, 8'h00, "hyg_ps");
    rd_chk(3'd0, 8'h00, "hyg_ctrl");
    rd_chk(3'd3, 8'h00, "hyg_rll");
    rd_chk(3'd7, 8'h00, "hyg_a7");

    // Reset in the middle of a count
    bus_wr(3'd2, 8'h00);
    bus_wr(3'd3, 8'h03);
    bus_wr(3'd0, 8'h07);
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(4);
    rd_chk(3'd1, 8'h00, "mr_stat");
    rd_chk(3'd0, 8'h00, "mr_ctrl");
    rd_chk(3'd3, 8'h00, "mr_rll");
    rd_chk(3'd6, RST_PS, "mr_ps");
    check("mr_irq", {7'd0, irq}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/timerio.md
Name: timerio

Overview:
- Memory-mapped 16-bit programmable interval timer on the 6801 CPU bus.
- Decoded at $E6B0–$E6B7 (DS5, AD[4:3]=2'b10), next to simpleio ($E6A0) and uartio ($E6A8).
- Its irq output is ORed into the CPU IRQ line. The CPU reads its registers through the top-level DI mux.
- Provides a periodic tick or a one-shot delay to firmware.

Parameters:
- RESET_PRESCALE, 8'h00, reset value of the PRESCALE register.

Ports:
- clk  input  1  system clock (sys_clk, CPU rate); all state updates on its rising edge
- rst  input  1  reset; synchronous and active-low
- AD  input  3  register select (CPU address bits [2:0])
- DI  input  8  write data from CPU
- DO  output  8  read data to CPU, combinational from AD and register state
- rw  input  1  1=read, 0=write
- cs  input  1  chip select, already qualified with vma
- irq  output  1  interrupt request, active high, level

Behaviour:
- Write strobe: cs && !rw, sampled at the clk edge. Read strobe: cs && rw.
- Register map:
  - 0 CTRL (RW): bit0 EN, bit1 AUTO (auto-reload), bit2 IE. Bits 7:3 read 0.
  - 1 STAT: bit0 TOF (write 1 clears), bit1 RUN (read-only copy of EN). Bits 7:2 read 0.
  - 2 RELOAD_H (RW): a write goes to staging byte RH_STG. A read returns the committed RELOAD[15:8].
  - 3 RELOAD_L (RW): a write commits RELOAD={RH_STG,DI}, loads COUNT={RH_STG,DI} and clears PCNT. A read returns RELOAD[7:0].
  - 4 COUNT_H (RO): a read returns COUNT[15:8] and, on that clk edge, latches COUNT[7:0] into CL_SNAP.
  - 5 COUNT_L (RO): a read returns CL_SNAP.
  - 6 PRESCALE (RW): 8-bit prescaler terminal value.
  - 7: reserved; reads 8'h00, writes ignored.
- Reset (rst=0 at a clk edge), next cycle:
  - CTRL=0, TOF=0, RELOAD=0, RH_STG=0, COUNT=0, CL_SNAP=0, PCNT=0, PRESCALE=RESET_PRESCALE.
  - irq=0; DO reflects the reset state.
  - Reset mid-count aborts all activity; no TOF is set.
- Prescaler:
  - While EN=1, 8-bit PCNT increments each clk.
  - When PCNT==PRESCALE, PCNT<=0 and a one-cycle internal tick fires.
  - PRESCALE=0 gives a tick every clk.
  - While EN=0, PCNT holds.
  - Writing CTRL with EN going 0->1 clears PCNT.
- Counter, on tick:
  - COUNT!=0: COUNT<=COUNT-1.
  - COUNT==0: TOF<=1. Then if AUTO=1, COUNT<=RELOAD. If AUTO=0, EN<=0 and COUNT stays 0.
  - Period in AUTO mode = (PRESCALE+1)*(RELOAD+1) clocks between TOF sets.
  - RELOAD=0 with AUTO=1 sets TOF on every tick.
- irq = TOF && IE, driven from registered state (no combinational path from bus inputs). irq stays asserted until TOF is cleared or IE is cleared.
- Simultaneous events:
  - TOF clear write and TOF set in the same cycle: set wins, TOF=1.
  - RELOAD_L write and tick in the same cycle: the write wins. COUNT takes the new value and the tick is discarded, no TOF.
  - CTRL write clearing EN and tick in the same cycle: the write wins, no decrement.
  - CTRL write and auto-clear of EN (one-shot expiry) in the same cycle: the CTRL write value wins; TOF is still set.
  - COUNT_H read in the same cycle as a decrement: CL_SNAP captures the pre-decrement low byte, coherent with the returned high byte.
- Wrap-around: COUNT never decrements below 0.
- Arithmetic: all 16-bit, unsigned.

Test Plan:
- Reset: drive rst=0 for 2 clks, then release -> all reads: CTRL=00, STAT=00, RELOAD_H/L=00, COUNT_H/L=00, PRESCALE=RESET_PRESCALE; irq=0.
- Auto-reload period: PRESCALE=3; RELOAD_H=00, RELOAD_L=04; CTRL=07 -> TOF sets every 20 clks; irq rises with TOF. Write STAT=01 -> irq falls the next cycle; TOF sets again 20 clks after the previous set.
- One-shot: PRESCALE=0, RELOAD=0002, CTRL=01 -> TOF sets 3 clks after enable; RUN reads 0; COUNT stays 0000; no further TOF after clearing.
- Coherent 16-bit read: RELOAD=0100, PRESCALE=0, run. Read COUNT_H while COUNT=0100 -> returns 01. Then COUNT_L, read 3 clks later -> returns 00 (snapshot), not FD.
- Collision: schedule STAT=01 write on the exact clk where TOF would set -> TOF reads 1. Schedule a RELOAD_L write on a tick clk -> COUNT equals the written value and no decrement occurs on that cycle.
- Bus hygiene: write to address 7, and writes with cs=0 -> no state change; address 7 reads 00; irq stays 0 with IE=0 even when TOF=1.
